// File: rtl/aes_pkg.sv
// Shared AES round definitions: FSM encodings, byte slicing and ShiftRows.
// Byte i of a state sits at [127-8i -: 8]; row = i%4, col = i/4.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] get_byte(
    input logic [127:0] s,
    input int           i
  );
    return s[127-8*i -: 8];
  endfunction

  // out[row r, col c] = in[row r, col (c+r) mod 4]
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          get_byte(s, 4*((c+r)%4)+r);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/sub_shift_rows_if.sv
// Start/done pulse handshake carrying one 128-bit AES state each way.
interface sub_shift_rows_if;
  logic         valid;
  logic [127:0] datain;
  logic         done;
  logic [127:0] dataout;

  modport master (
    output valid, datain,
    input  done, dataout
  );

  modport slave (
    input  valid, datain,
    output done, dataout
  );
endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational.
// One 16-byte table row per high nibble, low nibble picks the byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [127:0] row;
  logic [127:0] row_sh;

  always_comb begin
    row = '0;
    unique case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = '0;
    endcase
  end

  assign row_sh = row << {a[3:0], 3'b000};
  assign y      = row_sh[127:120];

endmodule

// File: rtl/sub_shift_rows.sv
// AES round front half: iterative SubBytes (LANES bytes/cycle) then ShiftRows.
// Feeds mixcolumn1 through the same valid/done pulse protocol.
module sub_shift_rows
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  sub_shift_rows_if.slave bus
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dout_q, dout_d;
  logic         done_q, done_d;

  logic [7:0]   sb_in  [LANES];
  logic [7:0]   sb_out [LANES];
  int           base;

  assign base = int'(cnt_q) * LANES;

  always_comb begin
    for (int g = 0; g < LANES; g++) begin
      sb_in[g] = get_byte(st_q, base + g);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .a (sb_in[g]),
      .y (sb_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    dout_d  = dout_q;
    done_d  = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          st_d    = bus.datain;
          cnt_d   = '0;
          dout_d  = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        for (int g = 0; g < LANES; g++) begin
          st_d[127-8*(base+g) -: 8] = sb_out[g];
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dout_d  = shift_rows(st_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign bus.done    = done_q;
  assign bus.dataout = dout_q;

endmodule

// File: tb/tb_sub_shift_rows.sv
// Bench for sub_shift_rows: reference S-box from GF(2^8) inversion,
// expected blocks queued at send time and popped on done.
module tb_sub_shift_rows;

  logic clk;
  logic rst;

  sub_shift_rows_if bus ();
  sub_shift_rows_if bus8 ();
  sub_shift_rows_if bus16 ();

  sub_shift_rows #(.LANES(4)) u4 (
    .clk (clk), .rst (rst), .bus (bus)
  );
  sub_shift_rows #(.LANES(8)) u8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );
  sub_shift_rows #(.LANES(16)) u16 (
    .clk (clk), .rst (rst), .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d);
    logic [127:0] s, o;
    for (int i = 0; i < 16; i++) s[127-8*i -: 8] = ref_sbox(d[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] ref_mixcol(input logic [127:0] d);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127-8*(4*c)   -: 8];
      a1 = d[127-8*(4*c+1) -: 8];
      a2 = d[127-8*(4*c+2) -: 8];
      a3 = d[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // Called at a falling edge; valid is held over exactly one rising edge.
  task automatic send(input logic [127:0] d);
    bus.valid  = 1'b1;
    bus.datain = d;
    exp_q.push_back(ref_model(d));
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    total++;
    if (bus.dataout !== 128'h0 || bus16.dataout !== 128'h0) begin
      bad++;
      $display("FAIL reset_dataout got=%h want=0", bus.dataout);
    end
  endtask

  task automatic test_fips;
    int lat;
    logic [127:0] e;
    send(FIPS_IN);
    wait_done(lat);
    e = exp_q.pop_front();
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL fips_latency got=%0d want=5", lat);
    end
    total++;
    if (bus.dataout !== FIPS_OUT || e !== FIPS_OUT) begin
      bad++;
      $display("FAIL fips_data got=%h want=%h", bus.dataout, FIPS_OUT);
    end
    total++;
    if (ref_mixcol(bus.dataout) !== FIPS_MC) begin
      bad++;
      $display("FAIL fips_mixcol got=%h want=%h", ref_mixcol(bus.dataout), FIPS_MC);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.dataout !== FIPS_OUT) begin
      bad++;
      $display("FAIL fips_hold got=%b/%h want=0/%h", bus.done, bus.dataout, FIPS_OUT);
    end
  endtask

  task automatic test_patterns;
    logic [127:0] pats [4];
    logic [127:0] e;
    int lat;
    pats[0] = {16{8'h00}};
    pats[1] = {16{8'hff}};
    pats[2] = {16{8'h53}};
    pats[3] = 128'h000102030405060708090a0b0c0d0e0f;
    for (int p = 0; p < 4; p++) begin
      send(pats[p]);
      wait_done(lat);
      e = exp_q.pop_front();
      total++;
      if (lat !== 5 || bus.dataout !== e) begin
        bad++;
        $display("FAIL pattern%0d got=%h lat=%0d want=%h lat=5", p, bus.dataout, lat, e);
      end
    end
    total++;
    if (bus.dataout !== 128'h636b6776f201ab7b30d777c5fe7c6f2b) begin
      bad++;
      $display("FAIL ordered_const got=%h want=636b6776f201ab7b30d777c5fe7c6f2b", bus.dataout);
    end
  endtask

  task automatic test_ignored_valid;
    int lat;
    logic [127:0] e;
    send(FIPS_IN);
    bus.valid  = 1'b1;
    bus.datain = {16{8'haa}};
    repeat (2) @(negedge clk);
    bus.valid = 1'b0;
    for (int i = 3; i <= 40; i++) begin
      lat = 0;
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    e = exp_q.pop_front();
    total++;
    if (lat !== 5 || bus.dataout !== e) begin
      bad++;
      $display("FAIL ignored_valid got=%h lat=%0d want=%h lat=5", bus.dataout, lat, e);
    end
    send({16{8'h53}});
    wait_done(lat);
    e = exp_q.pop_front();
    total++;
    if (lat !== 5 || bus.dataout !== e) begin
      bad++;
      $display("FAIL valid_in_done got=%h lat=%0d want=%h lat=5", bus.dataout, lat, e);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b want=0", bus.done);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [127:0] d, e;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(16*b + i);
      send(d);
      wait_done(lat);
      e = exp_q.pop_front();
      total++;
      if (lat !== 5 || bus.dataout !== e) begin
        bad++;
        $display("FAIL b2b_blk%0d got=%h lat=%0d want=%h lat=5", b, bus.dataout, lat, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int dones;
    int lat;
    logic [127:0] e;
    send(FIPS_IN);
    total++;
    if (bus.dataout !== 128'h0) begin
      bad++;
      $display("FAIL accept_clear got=%h want=0", bus.dataout);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    total++;
    if (bus.done !== 1'b0 || bus.dataout !== 128'h0) begin
      bad++;
      $display("FAIL abort_reset got=%b/%h want=0/0", bus.done, bus.dataout);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total++;
    if (dones !== 0 || bus.dataout !== 128'h0) begin
      bad++;
      $display("FAIL abort_nodone got=%0d/%h want=0/0", dones, bus.dataout);
    end
    send({16{8'hff}});
    wait_done(lat);
    e = exp_q.pop_front();
    total++;
    if (lat !== 5 || bus.dataout !== e) begin
      bad++;
      $display("FAIL after_abort got=%h lat=%0d want=%h lat=5", bus.dataout, lat, e);
    end
  endtask

  task automatic test_lanes;
    int l8, l16;
    logic [127:0] e;
    e = ref_model(FIPS_IN);
    bus8.valid   = 1'b1;
    bus8.datain  = FIPS_IN;
    bus16.valid  = 1'b1;
    bus16.datain = FIPS_IN;
    @(negedge clk);
    bus8.valid  = 1'b0;
    bus16.valid = 1'b0;
    l8  = 0;
    l16 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus8.done && l8 == 0) l8 = i;
      if (bus16.done && l16 == 0) l16 = i;
    end
    total++;
    if (l8 !== 3 || bus8.dataout !== e) begin
      bad++;
      $display("FAIL lanes8 got=%h lat=%0d want=%h lat=3", bus8.dataout, l8, e);
    end
    total++;
    if (l16 !== 2 || bus16.dataout !== e) begin
      bad++;
      $display("FAIL lanes16 got=%h lat=%0d want=%h lat=2", bus16.dataout, l16, e);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.valid    = 1'b0;
    bus.datain   = '0;
    bus8.valid   = 1'b0;
    bus8.datain  = '0;
    bus16.valid  = 1'b0;
    bus16.datain = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_fips();
    test_patterns();
    test_ignored_valid();
    test_back_to_back();
    test_abort();
    test_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
